// File: rtl/hamming_decoder_74.sv
// Hamming(7,4) single-error-correcting decoder with a one-cycle registered output stage.
// Optional saturating corrected-error counter enabled by defining HAMMING_ERR_COUNT_EN.
module hamming_decoder_74 #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [6:0]       data_in,
    input  logic             clr_count,
    output logic             out_valid,
    output logic [3:0]       ham_out,
    output logic [2:0]       syndrome,
    output logic             err_corrected,
    output logic [CNT_W-1:0] err_count
);

    logic [2:0] syn_c;
    logic [6:0] flip_c;
    logic [6:0] fixed_c;

    logic       valid_q, valid_d;
    logic [3:0] data_q,  data_d;
    logic [2:0] syn_q,   syn_d;
    logic       err_q,   err_d;

    // Syndrome equals the 1-based position of a single flipped bit; position p lives at index 7-p.
    always_comb begin
        syn_c[0] = data_in[6] ^ data_in[4] ^ data_in[2] ^ data_in[0];
        syn_c[1] = data_in[5] ^ data_in[4] ^ data_in[1] ^ data_in[0];
        syn_c[2] = data_in[3] ^ data_in[2] ^ data_in[1] ^ data_in[0];
        flip_c   = '0;
        if (syn_c != 3'd0) begin
            flip_c = 7'(7'd1 << (3'd7 - syn_c));
        end
        fixed_c  = data_in ^ flip_c;
    end

    // Capture on a valid word; otherwise hold payload and drop valid.
    always_comb begin
        valid_d = in_valid;
        data_d  = data_q;
        syn_d   = syn_q;
        err_d   = err_q;
        if (in_valid) begin
            data_d = {fixed_c[4], fixed_c[2], fixed_c[1], fixed_c[0]};
            syn_d  = syn_c;
            err_d  = (syn_c != 3'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            syn_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            syn_q   <= syn_d;
            err_q   <= err_d;
        end
    end

    assign out_valid     = valid_q;
    assign ham_out       = data_q;
    assign syndrome      = syn_q;
    assign err_corrected = err_q;

`ifdef HAMMING_ERR_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over increment; increment saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (in_valid && (syn_c != 3'd0) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;
`else
    logic unused_clr_count;

    assign unused_clr_count = clr_count;
    assign err_count        = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder_74.sv
// Self-checking bench for hamming_decoder_74: directed vectors, exhaustive single flips,
// random words against a nearest-codeword reference model, counter and async reset checks.
module tb_hamming_decoder_74;

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [6:0]       data_in = '0;
    logic             clr_count = 1'b0;
    logic             out_valid;
    logic [3:0]       ham_out;
    logic [2:0]       syndrome;
    logic             err_corrected;
    logic [CNT_W-1:0] err_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    logic       m_valid = 1'b0;
    logic [3:0] m_data  = '0;
    logic [2:0] m_syn   = '0;
    logic       m_err   = 1'b0;
    int         m_cnt   = 0;

    hamming_decoder_74 #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .data_in       (data_in),
        .clr_count     (clr_count),
        .out_valid     (out_valid),
        .ham_out       (ham_out),
        .syndrome      (syndrome),
        .err_corrected (err_corrected),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] c;
        c[4] = d[3];
        c[2] = d[2];
        c[1] = d[1];
        c[0] = d[0];
        c[6] = d[3] ^ d[2] ^ d[0];
        c[5] = d[3] ^ d[1] ^ d[0];
        c[3] = d[2] ^ d[1] ^ d[0];
        return c;
    endfunction

    function automatic logic [6:0] flip_pos(input logic [6:0] w, input int pos);
        logic [6:0] r;
        r = w;
        if (pos != 0) r[7 - pos] = ~r[7 - pos];
        return r;
    endfunction

    // Perfect code: every 7-bit word is a codeword or exactly one flip away from one.
    task automatic ref_decode(input logic [6:0] w, output logic [3:0] d_out, output logic [2:0] s_out);
        d_out = '0;
        s_out = '0;
        for (int d = 0; d < 16; d++) begin
            for (int p = 0; p < 8; p++) begin
                if (flip_pos(encode(4'(d)), p) == w) begin
                    d_out = 4'(d);
                    s_out = 3'(p);
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".ham_out"}, 32'(ham_out), 32'(m_data));
        check({tag, ".syndrome"}, 32'(syndrome), 32'(m_syn));
        check({tag, ".err_corrected"}, 32'(err_corrected), 32'(m_err));
        check({tag, ".err_count"}, 32'(err_count), 32'(m_cnt));
    endtask

    // Drive one cycle, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [6:0] w, input logic clr, input string tag);
        logic [3:0] d;
        logic [2:0] s;
        in_valid  = v;
        data_in   = w;
        clr_count = clr;
        ref_decode(w, d, s);
        m_valid = v;
        if (v) begin
            m_data = d;
            m_syn  = s;
            m_err  = (s != 3'd0);
        end
`ifdef HAMMING_ERR_COUNT_EN
        if (clr) m_cnt = 0;
        else if (v && s != 3'd0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
`endif
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        #1;
        check_all("reset_hold");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("after_reset");

        // Directed vectors.
        step(1'b1, 7'b0101010, 1'b0, "clean_0010");
        check("clean_0010.literal", 32'(ham_out), 32'h2);
        step(1'b1, 7'b0101011, 1'b0, "err_pos7");
        check("err_pos7.literal", 32'(syndrome), 32'd7);
        step(1'b1, 7'b0000001, 1'b0, "err_0000");
        step(1'b1, 7'b1001101, 1'b0, "err_0100");
        check("err_0100.literal", 32'(ham_out), 32'h4);
        step(1'b0, 7'b1111111, 1'b0, "idle_hold");
        step(1'b0, 7'b0000000, 1'b1, "idle_hold_clr");

        // Every data value with every single-bit flip, back to back.
        for (int d = 0; d < 16; d++) begin
            for (int p = 0; p < 8; p++) begin
                step(1'b1, flip_pos(encode(4'(d)), p), 1'b0, "flip_sweep");
                check("flip_sweep.data", 32'(ham_out), 32'(d));
                check("flip_sweep.pos", 32'(syndrome), 32'(p));
            end
        end

        // Counter saturation then clear alongside an erroneous word.
        step(1'b1, 7'b0000000, 1'b1, "cnt_clear");
        for (int i = 0; i < 5; i++) step(1'b1, 7'b0000001, 1'b0, "cnt_inc");
`ifdef HAMMING_ERR_COUNT_EN
        check("cnt_saturated", 32'(err_count), 32'd3);
`else
        check("cnt_disabled", 32'(err_count), 32'd0);
`endif
        step(1'b1, 7'b0000001, 1'b1, "cnt_clr_prio");
        check("cnt_clr_prio.zero", 32'(err_count), 32'd0);

        // Random words, gaps and clears.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 7'($urandom), ($urandom_range(0, 15) == 0), "random");
        end

        // Asynchronous reset while output is valid.
        step(1'b1, 7'b0101011, 1'b0, "pre_reset");
        #1;
        rst = 1'b1;
        #1;
        m_valid = 1'b0;
        m_data  = '0;
        m_syn   = '0;
        m_err   = 1'b0;
        m_cnt   = 0;
        check_all("async_reset");
        in_valid = 1'b1;
        data_in  = 7'b0101011;
        @(posedge clk);
        #1;
        check_all("reset_in_flight");
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 7'b0101011, 1'b0, "post_reset_idle0");
        step(1'b0, 7'b0000001, 1'b0, "post_reset_idle1");
        step(1'b1, 7'b1001101, 1'b0, "post_reset_first");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
